conv_layer_seq: RTL

Layer sequencer that drives `conv_top` through every output group of one convolution layer. For each group it reloads weights, applies per-group quant parameters, pulses `go` and gates the pixel stream. It then waits for `done`, flushes the line buffers with zero beats and soft-resets the datapath. It sits between the host/DMA streams (weights, pixels) and `conv_top`, and replaces the hand-sequenced flow the benches use today.

---
 rtl/conv_seq_pkg.sv | 31 +++
 rtl/conv_quant_table.sv | 25 ++
 rtl/conv_layer_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_pkg.sv
// Shared state encoding, sequencing constants and flush-length helper for the conv layer sequencer.
package conv_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WT_RST,
    WT_LOAD,
    GO,
    STREAM,
    WAIT_DONE,
    FLUSH,
    CRST,
    NEXT,
    FIN
  } seq_state_t;

  localparam int CONV_RST_HOLD   = 5;
  localparam int CONV_RST_SETTLE = 2;
  localparam int FLUSH_PAD       = 4;

  // Zero beats needed to push two full padded rows (8 channels per beat) out of the line buffers.
  function automatic logic [31:0] flush_beats(input logic [15:0] img_width,
                                              input logic [12:0] ch_beats);
    logic [31:0] w;
    logic [31:0] c;
    w = {16'd0, img_width};
    c = {19'd0, ch_beats};
    return ((w * c) << 1) + 32'(FLUSH_PAD);
  endfunction

endpackage

// File: rtl/conv_quant_table.sv
// Per-output-group quant parameters {M, N}: one write port, asynchronous read.
// Reads see the array contents before any same-cycle write.
module conv_quant_table #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_m,
  input  logic [4:0]            wr_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_m,
  output logic [4:0]            rd_n
);

  logic [36:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_m, wr_n};
  end

  assign {rd_m, rd_n} = mem[rd_addr];

endmodule

// File: rtl/conv_layer_seq.sv
// Sequences conv_top through every output group of a layer: weight reload, go, pixel gating, flush, soft reset.
// Datapath outputs are registered (1 cycle); source readies depend only on state/counters, never on valid.
module conv_layer_seq
  import conv_seq_pkg::*;
#(
  parameter int WT_ADDR_WIDTH   = 12,
  parameter int BIAS_GROUP_BITS = 7,
  parameter int MAX_CO_GROUPS   = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BIAS_GROUP_BITS:0]   lyr_co_groups,
  input  logic [9:0]                 lyr_ci_groups,
  input  logic [15:0]                lyr_img_width,
  input  logic [15:0]                lyr_in_channels,
  input  logic [15:0]                lyr_wt_words,
  input  logic                       lyr_use_relu,
  input  logic                       lyr_use_maxpool,
  input  logic                       lyr_stride_2,
  input  logic                       qt_wr_en,
  input  logic [BIAS_GROUP_BITS-1:0] qt_wr_addr,
  input  logic [31:0]                qt_wr_m,
  input  logic [4:0]                 qt_wr_n,
  input  logic                       wt_src_valid,
  output logic                       wt_src_ready,
  input  logic [71:0]                wt_src_data,
  input  logic                       pix_src_valid,
  output logic                       pix_src_ready,
  input  logic                       pix_src_last,
  input  logic [63:0]                pix_src_data,
  output logic                       conv_rst,
  output logic [9:0]                 cfg_ci_groups,
  output logic [15:0]                cfg_img_width,
  output logic [15:0]                cfg_in_channels,
  output logic [BIAS_GROUP_BITS-1:0] cfg_output_group,
  output logic [31:0]                cfg_quant_m,
  output logic [4:0]                 cfg_quant_n,
  output logic [WT_ADDR_WIDTH-1:0]   cfg_wt_base_addr,
  output logic                       cfg_use_relu,
  output logic                       cfg_use_maxpool,
  output logic                       cfg_stride_2,
  output logic                       go,
  output logic                       wt_wr_en,
  output logic [71:0]                wt_wr_data,
  output logic                       wt_wr_addr_rst,
  output logic [63:0]                pixel_in,
  output logic                       pixel_in_valid,
  output logic                       pixel_in_last,
  input  logic                       conv_done,
  output logic                       busy,
  output logic                       layer_done,
  output logic [BIAS_GROUP_BITS-1:0] cur_og
);

  seq_state_t                 state;
  logic [BIAS_GROUP_BITS-1:0] og;
  logic [BIAS_GROUP_BITS:0]   og_next;
  logic [BIAS_GROUP_BITS:0]   co_groups_q;
  logic [9:0]                 ci_groups_q;
  logic [15:0]                img_width_q;
  logic [15:0]                in_channels_q;
  logic [15:0]                wt_words_q;
  logic                       relu_q;
  logic                       maxpool_q;
  logic                       stride_2_q;
  logic [31:0]                flush_total;
  logic [31:0]                fl_cnt;
  logic [15:0]                wt_cnt;
  logic [2:0]                 crst_cnt;
  logic                       done_seen;
  logic                       wt_acc;
  logic                       pix_acc;
  logic [31:0]                qt_m;
  logic [4:0]                 qt_n;

  conv_quant_table #(
    .ADDR_WIDTH (BIAS_GROUP_BITS),
    .DEPTH      (MAX_CO_GROUPS)
  ) u_qt (
    .clk     (clk),
    .wr_en   (qt_wr_en),
    .wr_addr (qt_wr_addr),
    .wr_m    (qt_wr_m),
    .wr_n    (qt_wr_n),
    .rd_addr (og),
    .rd_m    (qt_m),
    .rd_n    (qt_n)
  );

  always_comb begin
    wt_src_ready  = (state == WT_LOAD) && (wt_cnt != wt_words_q);
    pix_src_ready = (state == STREAM);
    wt_acc        = wt_src_valid && wt_src_ready;
    pix_acc       = pix_src_valid && pix_src_ready;
    og_next       = {1'b0, og} + 1'b1;
  end

  assign cur_og = og;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      og               <= '0;
      co_groups_q      <= '0;
      ci_groups_q      <= '0;
      img_width_q      <= '0;
      in_channels_q    <= '0;
      wt_words_q       <= '0;
      relu_q           <= 1'b0;
      maxpool_q        <= 1'b0;
      stride_2_q       <= 1'b0;
      flush_total      <= '0;
      fl_cnt           <= '0;
      wt_cnt           <= '0;
      crst_cnt         <= '0;
      done_seen        <= 1'b0;
      conv_rst         <= 1'b0;
      cfg_ci_groups    <= '0;
      cfg_img_width    <= '0;
      cfg_in_channels  <= '0;
      cfg_output_group <= '0;
      cfg_quant_m      <= '0;
      cfg_quant_n      <= '0;
      cfg_wt_base_addr <= '0;
      cfg_use_relu     <= 1'b0;
      cfg_use_maxpool  <= 1'b0;
      cfg_stride_2     <= 1'b0;
      go               <= 1'b0;
      wt_wr_en         <= 1'b0;
      wt_wr_data       <= '0;
      wt_wr_addr_rst   <= 1'b0;
      pixel_in         <= '0;
      pixel_in_valid   <= 1'b0;
      pixel_in_last    <= 1'b0;
      busy             <= 1'b0;
      layer_done       <= 1'b0;
    end else begin
      go             <= 1'b0;
      wt_wr_addr_rst <= 1'b0;
      layer_done     <= 1'b0;
      conv_rst       <= 1'b0;
      pixel_in_valid <= 1'b0;
      pixel_in_last  <= 1'b0;
      wt_wr_en       <= wt_acc;
      if (wt_acc) wt_wr_data <= wt_src_data;
      // done may beat the last pixel; remember it until the next group's WT_RST
      if (conv_done && (state inside {STREAM, WAIT_DONE, FLUSH, CRST, NEXT})) done_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            co_groups_q   <= lyr_co_groups;
            ci_groups_q   <= lyr_ci_groups;
            img_width_q   <= lyr_img_width;
            in_channels_q <= lyr_in_channels;
            wt_words_q    <= lyr_wt_words;
            relu_q        <= lyr_use_relu;
            maxpool_q     <= lyr_use_maxpool;
            stride_2_q    <= lyr_stride_2;
            flush_total   <= flush_beats(lyr_img_width, lyr_in_channels[15:3]);
            og            <= '0;
            busy          <= 1'b1;
            state         <= (lyr_co_groups == '0) ? FIN : WT_RST;
          end
        end
        WT_RST: begin
          wt_wr_addr_rst   <= 1'b1;
          cfg_output_group <= og;
          cfg_quant_m      <= qt_m;
          cfg_quant_n      <= qt_n;
          cfg_wt_base_addr <= '0;
          cfg_ci_groups    <= ci_groups_q;
          cfg_img_width    <= img_width_q;
          cfg_in_channels  <= in_channels_q;
          cfg_use_relu     <= relu_q;
          cfg_use_maxpool  <= maxpool_q;
          cfg_stride_2     <= stride_2_q;
          done_seen        <= 1'b0;
          wt_cnt           <= '0;
          fl_cnt           <= '0;
          state            <= WT_LOAD;
        end
        WT_LOAD: begin
          if (wt_acc) wt_cnt <= wt_cnt + 16'd1;
          if ((wt_cnt == wt_words_q) || (wt_acc && (wt_cnt + 16'd1 == wt_words_q))) state <= GO;
        end
        GO: begin
          go    <= 1'b1;
          state <= STREAM;
        end
        STREAM: begin
          if (pix_acc) begin
            pixel_in_valid <= 1'b1;
            pixel_in       <= pix_src_data;
            pixel_in_last  <= pix_src_last;
            if (pix_src_last) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done_seen || conv_done) begin
            fl_cnt <= '0;
            state  <= FLUSH;
          end
        end
        FLUSH: begin
          pixel_in_valid <= 1'b1;
          pixel_in       <= '0;
          fl_cnt         <= fl_cnt + 32'd1;
          if (fl_cnt + 32'd1 == flush_total) begin
            crst_cnt <= '0;
            state    <= CRST;
          end
        end
        CRST: begin
          conv_rst <= (crst_cnt < 3'(CONV_RST_HOLD));
          crst_cnt <= crst_cnt + 3'd1;
          if (crst_cnt == 3'(CONV_RST_HOLD + CONV_RST_SETTLE - 1)) state <= NEXT;
        end
        NEXT: begin
          if (og_next == co_groups_q) begin
            state <= FIN;
          end else begin
            og    <= og_next[BIAS_GROUP_BITS-1:0];
            state <= WT_RST;
          end
        end
        FIN: begin
          layer_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
